// File: rtl/add_sub_pkg.sv
// Shared definitions for the sequential adder-subtractor: FSM states, mode codes, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of a counter that indexes n digits; never narrower than one bit
    // so a single-digit build still has a legal counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/add_sub_digit.sv
// Combinational DIGIT-bit ripple adder slice built from per-bit full adders.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module add_sub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_c;

    // Ripple the carry bit by bit through full-adder equations.
    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = w_c[DIGIT];
    // Carry into the top bit; XOR with cout gives signed overflow when this is the MSB digit.
    assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle add/subtract, DIGIT bits per clock with a registered carry; optional clamp via ADD_SUB_SAT_EN.
// Latency: WIDTH/DIGIT + 1 cycles from accepted START to the DONE pulse.
// Backpressure: START is ignored while BUSY; a START in the DONE cycle is accepted back-to-back.
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N);
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    // The subtract mode is folded into r_b (inverted) and the carry preset,
    // so no separate mode register is needed once the operation starts.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_s_dig;
    logic             w_cout_dig;
    logic             w_cmsb_dig;

    assign w_last  = (r_k == K_LAST);
    assign w_a_dig = r_a[r_k*DIGIT +: DIGIT];
    assign w_b_dig = r_b[r_k*DIGIT +: DIGIT];

    add_sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a        (w_a_dig),
        .b        (w_b_dig),
        .cin      (r_carry),
        .s        (w_s_dig),
        .cout     (w_cout_dig),
        .c_msb_in (w_cmsb_dig)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; START is only accepted outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch on accept, then one digit per cycle into S; flags only on the MSB digit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= (MODE == MODE_SUB) ? ~B : B;
            r_carry <= (MODE == MODE_SUB) ? ~CIN : CIN;
            r_k     <= '0;
        end else if (r_state == ST_RUN) begin
            r_s[r_k*DIGIT +: DIGIT] <= w_s_dig;
            r_carry                 <= w_cout_dig;
            r_k                     <= w_last ? '0 : r_k + 1'b1;
            if (w_last) begin
                r_cout <= w_cout_dig;
                r_ovf  <= w_cmsb_dig ^ w_cout_dig;
`ifdef ADD_SUB_SAT_EN
                // On overflow both effective operands share A's sign, so A's sign picks the rail.
                if (w_cmsb_dig ^ w_cout_dig) begin
                    r_s <= r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
        end
    end

    assign BUSY = (r_state == ST_RUN);
    assign DONE = (r_state == ST_DONE);
    assign S    = r_s;
    assign COUT = r_cout;
    assign OVF  = r_ovf;

endmodule

// File: doc/add_sub_seq.md
# add_sub_seq

Parametrised, multi-cycle signed/unsigned adder-subtractor for the ALU datapath. Processes operands DIGIT bits per clock through a registered carry chain, trading latency for area on wide operands. Uses a start/done handshake toward the ALU control sequencer. Reports carry-out and signed overflow.

## Interface
- WIDTH, 8: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 2: bits processed per clock; 1 ≤ DIGIT ≤ WIDTH.
- CLK  input  1  rising-edge clock; single clock domain.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled on the rising edge of CLK.
- MODE  input  1  0 = add, 1 = subtract; latched with START.
- A  input  WIDTH  operand A; latched with START.
- B  input  WIDTH  operand B; latched with START.
- CIN  input  1  carry-in for add, borrow-in for subtract; latched with START.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse; S, COUT and OVF are valid.
- S  output  WIDTH  result; held until the next accepted START.
- COUT  output  1  final carry; in subtract mode it is not-borrow.
- OVF  output  1  two's-complement signed overflow.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE or DONE, START=1:**
  - Latch A, MODE and CIN.
  - Latch B as B when MODE=0, or ~B when MODE=1.
  - Preset the carry register to CIN when MODE=0, or !CIN when MODE=1.
  - Clear the digit counter to 0 and go to RUN.
- **IDLE or DONE, START=0:** go to or stay in IDLE.
- **Arithmetic:**
  - Add: S = A + B + CIN.
  - Subtract: S = A − B − CIN, computed as A + ~B + !CIN.
  - All sums are modulo 2^WIDTH.
- **RUN:**
  - Each cycle adds digit k (bits k·DIGIT+DIGIT−1 : k·DIGIT) of A and the latched B with the carry register.
  - Write the digit result into S and the new carry into the carry register.
  - Increment k.
  - When k = N−1 (N = WIDTH/DIGIT), go to DONE.
- **Flags:**
  - COUT = carry out of the MSB digit.
  - OVF = carry into the MSB XOR carry out of the MSB. Capture it while the MSB digit is processed.
- **START while BUSY:** ignored; the operands are not re-latched.
- **START in the DONE cycle:** accepted. Back-to-back operations run with no idle cycle.
- **Reset (asynchronous, at any time, including mid-RUN):**
  - State goes to IDLE; k = 0.
  - S = 0, COUT = 0, OVF = 0, BUSY = 0, DONE = 0.
  - The partial result is discarded; no DONE pulse follows.
- **MODE, A, B, CIN changes during RUN:** no effect.

## Timing
- START is high in cycle 0. BUSY is high in cycles 1..N. DONE is high in cycle N+1 only.
- Latency from START to DONE is N+1 cycles. For WIDTH=8, DIGIT=2 this is 5.
- Throughput is one operation per N+1 cycles.
- S is partially updated during RUN and is not valid until DONE.
- COUT and OVF change only on the edge that enters DONE.
- DIGIT = WIDTH gives N=1: BUSY for one cycle, DONE in cycle 2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ADD_SUB_SAT_EN defined: S is clamped when OVF=1.
  - Positive overflow gives 0x7F..F; negative overflow gives 0x80..0.
  - The clamp is applied on the edge that enters DONE; OVF still reports the overflow.
  - COUT is unaffected.
- ADD_SUB_SAT_EN undefined: S is always the wrapped modulo result. No saturation logic is compiled.

## Structure
- add_sub_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - MODE_ADD = 0 and MODE_SUB = 1;
  - the counter-width function clog2(WIDTH/DIGIT).
- Sub-module add_sub_digit (parameter DIGIT) is a combinational DIGIT-bit ripple adder built from per-bit full-adder equations.
  - Inputs: a, b, cin. Outputs: s, cout, and c_msb_in, the carry into its top bit, used for OVF.
- The top level holds the FSM, operand registers, digit counter, carry register, result assembly and the optional saturation.

## Test plan
- WIDTH=8, DIGIT=2; add 0x7F + 0x01, CIN=0 → S=0x80, COUT=0, OVF=1. BUSY in cycles 1–4, DONE in cycle 5 only.
- Subtract 0x05 − 0x07, CIN=0 → S=0xFE, COUT=0, OVF=0. Subtract 0x80 − 0x01 → S=0x7F, COUT=1, OVF=1.
- Add 0xFF + 0x00, CIN=1 → S=0x00, COUT=1, OVF=0. Then issue START in the DONE cycle with 0x10 + 0x20 → S=0x30, DONE 5 cycles later.
- START pulse during cycle 2 of RUN with different operands → ignored. The original result completes; no second DONE.
- Assert RST_N low in cycle 3 of RUN → all outputs 0 immediately, state IDLE. No DONE appears afterwards.
- With ADD_SUB_SAT_EN: 0x7F + 0x01 → S=0x7F, OVF=1; 0x80 − 0x01 → S=0x80, OVF=1. Repeat with DIGIT=1 and DIGIT=8 → same results, DONE after 9 and 2 cycles respectively.
